frame_burst_buffer: RTL

- Upstream stage for the frame-reversal block.
- Accepts a gappy, back-pressured sample stream and stores it in a circular buffer holding FRAMES frames.
- Releases each complete N-sample frame as one contiguous burst of N valid beats, with a last-beat marker.
- Downstream has no ready, so this block isolates source stalls and gaps from it.

---
 rtl/frame_burst_buffer_pkg.sv | 15 +
 rtl/frame_burst_buffer_if.sv | 23 ++
 rtl/sdp_ram.sv | 29 ++
 rtl/frame_burst_buffer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/frame_burst_buffer_pkg.sv
// Shared types and helpers for the frame burst buffer and the frame-reversal counters.
// Holds the burst FSM state type and a wrap-around increment for non power-of-two ranges.
package frame_burst_buffer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // limit is the highest legal value; the result returns to 0 after it
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned limit);
      return (ptr >= limit) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/frame_burst_buffer_if.sv
// Sample-side and burst-side signals of the frame burst buffer.
// slave is the buffer's view, master is the view of whatever drives and observes it.
interface frame_burst_buffer_if #(
   parameter int BITS = 8
);
   logic            s_valid;
   logic            s_ready;
   logic [BITS-1:0] s_data;
   logic            abort;
   logic            m_valid;
   logic [BITS-1:0] m_data;
   logic            m_last;

   modport master (
      output s_valid, s_data, abort,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_valid, s_data, abort,
      output s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Storage carries no reset; only the read register clears so the burst output starts at 0.
module sdp_ram #(
   parameter int BITS  = 8,
   parameter int DEPTH = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [BITS-1:0]          wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [BITS-1:0]          rdata
);

   logic [BITS-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // rdata holds between reads so the burst output keeps its last sample while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/frame_burst_buffer.sv
// Circular frame buffer: absorbs a gappy, back-pressured sample stream and replays each
// complete N-sample frame as one unbroken burst with a last-beat marker.
module frame_burst_buffer
   import frame_burst_buffer_pkg::*;
#(
   parameter int BITS   = 8,
   parameter int N      = 10,
   parameter int FRAMES = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   frame_burst_buffer_if.slave            bus,
   output logic [$clog2(FRAMES+1)-1:0]    frames_stored
);

   localparam int          DEPTH     = N * FRAMES;
   localparam int          PTR_W     = $clog2(DEPTH);
   localparam int          OCC_W     = $clog2(DEPTH + 1);
   localparam int          IDX_W     = $clog2(N);
   localparam int          FS_W      = $clog2(FRAMES + 1);
   localparam int unsigned LAST_SLOT = DEPTH - 1;

   logic [PTR_W-1:0] wr_ptr, frm_ptr, rd_ptr, wr_ptr_inc;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [OCC_W-1:0] occupancy, occ_nxt;
   logic [BITS-1:0]  rd_data;
   state_t           state, state_nxt;
   logic             wr_acc, frame_done, last_beat, issue, burst_end;

   assign bus.s_ready = (occupancy < OCC_W'(DEPTH));
   assign wr_acc      = bus.s_valid && bus.s_ready && !bus.abort;
   assign frame_done  = wr_acc && (wr_idx == IDX_W'(N - 1));
   assign last_beat   = (rd_idx == IDX_W'(N - 1));
   assign wr_ptr_inc  = PTR_W'(wrap_inc(32'(wr_ptr), LAST_SLOT));
   assign bus.m_data  = rd_data;

   // A frame completing on the same edge as a burst end keeps the burst going gap-free
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      burst_end = 1'b0;
      case (state)
         IDLE: begin
            if (frames_stored != '0) begin
               issue     = 1'b1;
               state_nxt = BURST;
            end
         end
         BURST: begin
            issue = 1'b1;
            if (last_beat) begin
               burst_end = 1'b1;
               state_nxt = (frames_stored > FS_W'(1) || frame_done) ? BURST : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      occ_nxt = occupancy + OCC_W'(wr_acc) - OCC_W'(issue);
      if (bus.abort) occ_nxt = occ_nxt - OCC_W'(wr_idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Write side: frm_ptr remembers where the partial frame began so abort can rewind to it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         frm_ptr       <= '0;
         wr_idx        <= '0;
         occupancy     <= '0;
         frames_stored <= '0;
      end else begin
         occupancy     <= occ_nxt;
         frames_stored <= frames_stored + FS_W'(frame_done) - FS_W'(burst_end);
         if (bus.abort) begin
            wr_ptr <= frm_ptr;
            wr_idx <= '0;
         end else if (wr_acc) begin
            wr_ptr <= wr_ptr_inc;
            if (frame_done) begin
               wr_idx  <= '0;
               frm_ptr <= wr_ptr_inc;
            end else begin
               wr_idx <= wr_idx + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         rd_idx      <= '0;
         bus.m_valid <= 1'b0;
         bus.m_last  <= 1'b0;
      end else begin
         bus.m_valid <= issue;
         bus.m_last  <= issue && last_beat;
         if (issue) begin
            rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), LAST_SLOT));
            rd_idx <= last_beat ? '0 : rd_idx + IDX_W'(1);
         end
      end
   end

   sdp_ram #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (bus.s_data),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

endmodule
